// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between the instruction cache and the
// data cache. Data requests win arbitration unless an instruction fetch has
// already been passed over STARVE_MAX times in a row. Each access is tracked
// by a small FSM that returns a one-cycle completion (iwait/dwait low) to the
// granted cache, and RAM errors or timeouts complete the access with a poison
// word and set a sticky error flag.
module mem_arbiter #(
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic        CLK,
   input  logic        RST,
   // instruction cache side
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic [31:0] iload,
   output logic        iwait,
   // data cache side
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic [31:0] dload,
   output logic        dwait,
   // RAM side
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   // sticky error
   output logic        merr
);

   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [1:0]  RAM_ACCESS = 2'd2;
   localparam logic [1:0]  RAM_ERROR  = 2'd3;
   localparam logic [31:0] POISON     = 32'hBAD1BAD1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ISVC = 2'd1,
      DSVC = 2'd2
   } state_t;

   state_t        state, next_state;
   logic [SW-1:0] scnt;
   logic [TW-1:0] tcnt;

   logic d_req;      // any data request line high
   logic d_rd;       // data read (a simultaneous write wins)
   logic scnt_sat;   // instruction side has been passed over STARVE_MAX times
   logic svc_req;    // granted requester still asserting its request
   logic tmo;        // current access has waited TIMEOUT cycles
   logic complete;   // access finishes this cycle
   logic fail;       // finishing access is an error or a timeout

   assign d_req    = dREN | dWEN;
   assign d_rd     = dREN & ~dWEN;
   assign scnt_sat = (scnt == SW'(STARVE_MAX));
   assign tmo      = (tcnt == TW'(TIMEOUT));

   // Request, completion and failure qualifiers for the current service state
   always_comb begin
      // NOTE: every signal gets a default before the case, so no path can
      // leave it unassigned and infer a latch.
      svc_req  = 1'b0;
      complete = 1'b0;
      fail     = 1'b0;
      if (state == ISVC) begin
         svc_req = iREN;
      end else if (state == DSVC) begin
         svc_req = d_req;
      end
      if (svc_req) begin
         complete = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR) || tmo;
         fail     = (ramstate == RAM_ERROR) || (tmo && (ramstate != RAM_ACCESS));
      end
   end

   // State register, starvation counter, timeout counter and sticky error
   always_ff @(posedge CLK) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (RST) begin
         state <= IDLE;
         scnt  <= '0;
         tcnt  <= '0;
         merr  <= 1'b0;
      end else begin
         state <= next_state;

         if (state == IDLE) begin
            if (!iREN) begin
               scnt <= '0;
            end else if (next_state == DSVC) begin
               if (!scnt_sat) begin
                  scnt <= scnt + SW'(1);
               end
            end else if (next_state == ISVC) begin
               scnt <= '0;
            end
         end

         if (state == IDLE) begin
            tcnt <= '0;
         end else if (!complete) begin
            tcnt <= tcnt + TW'(1);
         end

         if (complete && fail) begin
            merr <= 1'b1;
         end
      end
   end

   // Next-state: arbitrate in IDLE, leave service on completion or withdrawal
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (d_req && (!iREN || !scnt_sat)) begin
               next_state = DSVC;
            end else if (iREN) begin
               next_state = ISVC;
            end else begin
               next_state = IDLE;
            end
         end
         ISVC, DSVC: begin
            if (!svc_req || complete) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs: steer the granted requester onto the RAM port and return data
   always_comb begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      iload    = '0;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      case (state)
         ISVC: begin
            ramREN  = iREN;
            ramaddr = iaddr;
            if (complete) begin
               iwait = 1'b0;
               iload = fail ? POISON : ramload;
            end
         end
         DSVC: begin
            ramREN   = d_rd;
            ramWEN   = dWEN;
            ramaddr  = daddr;
            ramstore = dstore;
            if (complete) begin
               dwait = 1'b0;
               if (d_rd) begin
                  dload = fail ? POISON : ramload;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors against mem_arbiter with a behavioural
// RAM. Expected completions (side + load data) are queued by the stimulus and
// checked by an independent monitor whenever iwait or dwait drops.
module tb_mem_arbiter;

   localparam int BOUND = 50;
   localparam logic [1:0] R_FREE = 2'd0, R_BUSY = 2'd1, R_ACCESS = 2'd2, R_ERROR = 2'd3;

   logic        CLK, RST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore;
   logic [31:0] iload, dload, ramaddr, ramstore, ramload;
   logic        iwait, dwait, ramREN, ramWEN, merr;
   logic [1:0]  ramstate;

   mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(8)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .merr(merr)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // ---------------- behavioural RAM ----------------
   logic [31:0] mem [0:255];
   int lat;
   bit err_mode, hang;
   int wcnt;
   logic strobe;

   assign strobe  = ramREN | ramWEN;
   assign ramload = mem[ramaddr[9:2]];

   always_comb begin
      if (!strobe)                 ramstate = R_FREE;
      else if (hang)               ramstate = R_BUSY;
      else if (err_mode)           ramstate = R_ERROR;
      else if (wcnt >= lat)        ramstate = R_ACCESS;
      else                         ramstate = R_BUSY;
   end

   always @(posedge CLK) begin
      if (strobe && ramstate == R_BUSY) wcnt <= wcnt + 1;
      else                              wcnt <= 0;
      if (ramWEN && ramstate == R_ACCESS) mem[ramaddr[9:2]] <= ramstore;
   end

   // ---------------- scoreboard ----------------
   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_done = 0;
   int   ren_cyc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic push_exp(input bit is_d, input logic [31:0] data);
      exp_t e;
      e.is_d = is_d;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic cmp_done(input bit is_d, input logic [31:0] data);
      exp_t e;
      n_done++;
      if (sb.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL spurious_completion: side=%0d data=%h, expected no completion (t=%0t)",
                  is_d, data, $time);
      end else begin
         e = sb.pop_front();
         check("grant_side", {31'b0, is_d}, {31'b0, e.is_d});
         check("load_data", data, e.data);
      end
   endtask

   // Monitor: compare every completion pulse against the queue
   always @(negedge CLK) begin
      if (!RST) begin
         if (!iwait) cmp_done(1'b0, iload);
         if (!dwait) cmp_done(1'b1, dload);
         if (ramREN) ren_cyc++;
      end
   end

   // ---------------- requester tasks (start/end at #1 after posedge) -------
   task automatic run_i(input logic [31:0] addr, output int cyc);
      iREN  = 1'b1;
      iaddr = addr;
      cyc   = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (iwait === 1'b1 && cyc < BOUND);
      check("i_done_seen", {31'b0, ~iwait}, 32'd1);
      @(posedge CLK);
      #1;
      iREN  = 1'b0;
      iaddr = '0;
   endtask

   task automatic run_d(input logic ren, input logic wen,
                        input logic [31:0] addr, input logic [31:0] data,
                        output int cyc, output logic [31:0] p_addr,
                        output logic [31:0] p_store, output logic p_ren,
                        output logic p_wen);
      dREN   = ren;
      dWEN   = wen;
      daddr  = addr;
      dstore = data;
      cyc    = 0;
      do begin
         @(negedge CLK);
         cyc++;
      end while (dwait === 1'b1 && cyc < BOUND);
      check("d_done_seen", {31'b0, ~dwait}, 32'd1);
      p_addr  = ramaddr;
      p_store = ramstore;
      p_ren   = ramREN;
      p_wen   = ramWEN;
      @(posedge CLK);
      #1;
      dREN   = 1'b0;
      dWEN   = 1'b0;
      daddr  = '0;
      dstore = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      @(posedge CLK);
      #1;
      RST = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      int          ci, cd, base, guard, r0;
      logic [31:0] pa, ps;
      logic        pr, pw;

      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[16] = 32'h8C220004;   // 0x40
      mem[32] = 32'h12345678;   // 0x80
      lat = 0; err_mode = 0; hang = 0;
      RST = 1'b1; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = '0; daddr = '0; dstore = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;

      // Reset state
      check("rst_iwait",    {31'b0, iwait},  32'd1);
      check("rst_dwait",    {31'b0, dwait},  32'd1);
      check("rst_iload",    iload,           32'd0);
      check("rst_dload",    dload,           32'd0);
      check("rst_strobes",  {30'b0, ramREN, ramWEN}, 32'd0);
      check("rst_ramaddr",  ramaddr,         32'd0);
      check("rst_ramstore", ramstore,        32'd0);
      check("rst_merr",     {31'b0, merr},   32'd0);

      // Isolated fetch, zero-wait RAM
      r0 = ren_cyc;
      push_exp(1'b0, 32'h8C220004);
      run_i(32'h40, ci);
      check("fetch_latency", 32'(ci), 32'd2);
      @(negedge CLK);
      #1;
      check("fetch_ren_cycles", 32'(ren_cyc - r0), 32'd1);
      @(posedge CLK);
      #1;

      // Simultaneous: write (dREN&dWEN) wins, fetch follows
      push_exp(1'b1, 32'h0);
      push_exp(1'b0, 32'h8C220004);
      fork
         run_d(1'b1, 1'b1, 32'h100, 32'hDEADBEEF, cd, pa, ps, pr, pw);
         run_i(32'h40, ci);
      join
      check("sim_d_latency", 32'(cd), 32'd2);
      check("sim_i_latency", 32'(ci), 32'd4);
      check("sim_ramaddr",   pa, 32'h100);
      check("sim_ramstore",  ps, 32'hDEADBEEF);
      check("sim_strobes",   {30'b0, pr, pw}, 32'd1);
      check("sim_mem_write", mem[64], 32'hDEADBEEF);

      // Starvation: D,D,D,D,I repeating
      for (int k = 0; k < 2; k++) begin
         for (int j = 0; j < 4; j++) push_exp(1'b1, 32'h12345678);
         push_exp(1'b0, 32'h8C220004);
      end
      base = n_done;
      iREN = 1'b1; iaddr = 32'h40;
      dREN = 1'b1; daddr = 32'h80;
      guard = 0;
      while (n_done < base + 10 && guard < 200) begin
         @(negedge CLK);
         #1;
         guard++;
      end
      check("starve_count", 32'(n_done - base), 32'd10);
      @(posedge CLK);
      #1;
      iREN = 1'b0; dREN = 1'b0; iaddr = '0; daddr = '0;
      @(posedge CLK);
      #1;

      // RAM latency: 3 BUSY cycles then ACCESS on a data read
      lat = 3;
      push_exp(1'b1, 32'h12345678);
      run_d(1'b1, 1'b0, 32'h80, 32'h0, cd, pa, ps, pr, pw);
      check("busy_latency", 32'(cd), 32'd5);
      check("busy_merr",    {31'b0, merr}, 32'd0);
      lat = 0;

      // ERROR on a fetch
      err_mode = 1;
      push_exp(1'b0, 32'hBAD1BAD1);
      run_i(32'h40, ci);
      err_mode = 0;
      check("err_latency", 32'(ci), 32'd2);
      check("err_merr",    {31'b0, merr}, 32'd1);
      do_reset();
      check("err_merr_cleared", {31'b0, merr}, 32'd0);

      // Timeout on a data read: completes at service cycle 9
      hang = 1;
      push_exp(1'b1, 32'hBAD1BAD1);
      run_d(1'b1, 1'b0, 32'h80, 32'h0, cd, pa, ps, pr, pw);
      hang = 0;
      check("tmo_latency", 32'(cd), 32'd10);
      check("tmo_merr",    {31'b0, merr}, 32'd1);

      // Reset mid-service during a BUSY write, then the request is regranted
      hang = 1;
      dWEN = 1'b1; daddr = 32'h104; dstore = 32'hCAFEF00D;
      repeat (3) @(posedge CLK);
      #1;
      check("mid_wen_before", {31'b0, ramWEN}, 32'd1);
      do_reset();
      check("mid_wen_after",  {31'b0, ramWEN}, 32'd0);
      check("mid_dwait",      {31'b0, dwait},  32'd1);
      check("mid_merr",       {31'b0, merr},   32'd0);
      hang = 0;
      push_exp(1'b1, 32'h0);
      guard = 0;
      do begin
         @(negedge CLK);
         guard++;
      end while (dwait === 1'b1 && guard < BOUND);
      check("mid_regrant_latency", 32'(guard), 32'd2);
      @(posedge CLK);
      #1;
      dWEN = 1'b0; daddr = '0; dstore = '0;
      check("mid_mem_write", mem[65], 32'hCAFEF00D);

      @(negedge CLK);
      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
